branch_redirect_arb: RTL and testbench

Backend arbiter directly downstream of the misc/branch functional units. Each cycle it collects completion results from every branch-capable unit and selects the oldest mispredicted branch. It holds that branch as a registered redirect to the frontend until the frontend accepts it, and broadcasts the same redirect as a squash to the backend. It drops results from branches that an already-issued redirect has made stale.

---
 rtl/branch_redirect_arb_pkg.sv | 25 ++
 rtl/branch_redirect_arb_bru_oldest_sel.sv | 39 +++
 rtl/branch_redirect_arb.sv | 123 ++++++++++++
 tb/tb_branch_redirect_arb.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_redirect_arb_pkg.sv
// Shared backend package: ROB index type and age helper.
//
// robIdx_t is {flag, idx}. The flag toggles each time the ROB allocation
// pointer wraps, so two indices with different flags straddle a wrap.
// rob_is_older(a, b) is reused by the ROB, LSQ and issue queues.
package branch_redirect_arb_pkg;

    localparam int XLEN         = 32;
    localparam int ROB_SIZE_DEF = 64;
    localparam int ROB_IDX_W    = $clog2(ROB_SIZE_DEF);

    typedef struct packed {
        logic                 flag;
        logic [ROB_IDX_W-1:0] idx;
    } robIdx_t;

    // True when a was allocated strictly before b. Equal indices are not older.
    function automatic logic rob_is_older(input robIdx_t a, input robIdx_t b);
        if (a.flag == b.flag) begin
            return a.idx < b.idx;
        end
        return a.idx > b.idx;
    endfunction

endpackage

// File: rtl/branch_redirect_arb_bru_oldest_sel.sv
// bru_oldest_sel: combinational NUM_BRU-way oldest-valid select.
//
// Ports:
//   cand_vld[NUM_BRU]    in   candidate valid
//   cand_robIdx[NUM_BRU] in   candidate ROB index
//   cand_npc[NUM_BRU]    in   candidate restart pc
//   sel_vld              out  any candidate valid
//   sel_robIdx           out  ROB index of the oldest candidate
//   sel_npc              out  restart pc of the oldest candidate
//
// Ports are scanned from 0 upward and a later port replaces the current
// choice only when strictly older, so on equal age the lower port wins.
module bru_oldest_sel
    import branch_redirect_arb_pkg::*;
#(
    parameter int NUM_BRU = 2
) (
    input  logic            cand_vld    [NUM_BRU],
    input  robIdx_t         cand_robIdx [NUM_BRU],
    input  logic [XLEN-1:0] cand_npc    [NUM_BRU],
    output logic            sel_vld,
    output robIdx_t         sel_robIdx,
    output logic [XLEN-1:0] sel_npc
);

    always_comb begin
        sel_vld    = 1'b0;
        sel_robIdx = '0;
        sel_npc    = '0;
        for (int i = 0; i < NUM_BRU; i++) begin
            if (cand_vld[i] && (!sel_vld || rob_is_older(cand_robIdx[i], sel_robIdx))) begin
                sel_vld    = 1'b1;
                sel_robIdx = cand_robIdx[i];
                sel_npc    = cand_npc[i];
            end
        end
    end

endmodule

// File: rtl/branch_redirect_arb.sv
// branch_redirect_arb: picks the oldest mispredicted branch among the
// branch-capable FU results, holds it as a registered redirect to the
// frontend and drops results made stale by an already-issued redirect.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_bru_vld/robIdx/misPred/npc [NUM_BRU]  FU completion results
//   i_commit_vld/robIdx      ROB commit of one instruction
//   i_rob_flush              global flush (exception/interrupt)
//   o_redirect_vld/robIdx/pc registered redirect to frontend / squash to backend
//   i_redirect_rdy           frontend accepts redirect
//   o_filter_vld             stale-result filter active
//
// Redirect handshake: a transfer happens on every cycle where
// o_redirect_vld & i_redirect_rdy are both high. While vld is high and rdy
// is low the payload may change, but only to an older branch. A flush or
// reset drops a pending redirect without a transfer.
module branch_redirect_arb
    import branch_redirect_arb_pkg::*;
#(
    parameter int NUM_BRU  = 2,
    parameter int ROB_SIZE = ROB_SIZE_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_bru_vld      [NUM_BRU],
    input  robIdx_t         i_bru_robIdx   [NUM_BRU],
    input  logic            i_bru_misPred  [NUM_BRU],
    input  logic [XLEN-1:0] i_bru_npc      [NUM_BRU],
    input  logic            i_commit_vld,
    input  robIdx_t         i_commit_robIdx,
    input  logic            i_rob_flush,
    output logic            o_redirect_vld,
    output robIdx_t         o_redirect_robIdx,
    output logic [XLEN-1:0] o_redirect_pc,
    input  logic            i_redirect_rdy,
    output logic            o_filter_vld
);

    // robIdx_t is sized by the package; the parameter only documents that.
    if (ROB_SIZE != ROB_SIZE_DEF) begin : g_rob_size_check
        $error("ROB_SIZE must match the robIdx_t width in branch_redirect_arb_pkg");
    end

    logic            pend_vld;
    robIdx_t         pend_robIdx;
    logic [XLEN-1:0] pend_pc;
    logic            filt_vld;
    robIdx_t         filt_robIdx;

    logic            cand_vld [NUM_BRU];
    logic            win_vld;
    robIdx_t         win_robIdx;
    logic [XLEN-1:0] win_npc;
    logic            win_older;
    logic            accept;

    // A result is stale once a redirect at or older than it has been handed
    // to the frontend: everything not older than filt_robIdx is squashed.
    always_comb begin
        for (int i = 0; i < NUM_BRU; i++) begin
            cand_vld[i] = i_bru_vld[i] && i_bru_misPred[i] &&
                          !(filt_vld && !rob_is_older(i_bru_robIdx[i], filt_robIdx));
        end
    end

    bru_oldest_sel #(
        .NUM_BRU (NUM_BRU)
    ) u_sel (
        .cand_vld    (cand_vld),
        .cand_robIdx (i_bru_robIdx),
        .cand_npc    (i_bru_npc),
        .sel_vld     (win_vld),
        .sel_robIdx  (win_robIdx),
        .sel_npc     (win_npc)
    );

    assign win_older = win_vld && rob_is_older(win_robIdx, pend_robIdx);
    assign accept    = pend_vld && i_redirect_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld    <= 1'b0;
            pend_robIdx <= '0;
            pend_pc     <= '0;
            filt_vld    <= 1'b0;
            filt_robIdx <= '0;
        end else if (i_rob_flush) begin
            pend_vld <= 1'b0;
            filt_vld <= 1'b0;
        end else begin
            // Commit of the filtering branch releases the filter; a same-cycle
            // accept below takes precedence and re-arms it.
            if (filt_vld && i_commit_vld && (i_commit_robIdx == filt_robIdx)) begin
                filt_vld <= 1'b0;
            end
            if (accept) begin
                filt_vld    <= 1'b1;
                filt_robIdx <= pend_robIdx;
                pend_vld    <= win_older;
                if (win_older) begin
                    pend_robIdx <= win_robIdx;
                    pend_pc     <= win_npc;
                end
            end else if (pend_vld) begin
                if (win_older) begin
                    pend_robIdx <= win_robIdx;
                    pend_pc     <= win_npc;
                end
            end else if (win_vld) begin
                pend_vld    <= 1'b1;
                pend_robIdx <= win_robIdx;
                pend_pc     <= win_npc;
            end
        end
    end

    assign o_redirect_vld    = pend_vld;
    assign o_redirect_robIdx = pend_robIdx;
    assign o_redirect_pc     = pend_pc;
    assign o_filter_vld      = filt_vld;

endmodule

// File: tb/tb_branch_redirect_arb.sv
// Self-checking bench for branch_redirect_arb: directed scenarios followed
// by randomized traffic, all checked against a reference model that treats
// ROB indices as positions on a modulo-2*ROB_SIZE ring.
module tb_branch_redirect_arb;
    import branch_redirect_arb_pkg::*;

    localparam int NUM_BRU = 2;
    localparam int RING    = 2 * ROB_SIZE_DEF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            bru_vld     [NUM_BRU];
    robIdx_t         bru_robIdx  [NUM_BRU];
    logic            bru_misPred [NUM_BRU];
    logic [XLEN-1:0] bru_npc     [NUM_BRU];
    logic            commit_vld;
    robIdx_t         commit_robIdx;
    logic            rob_flush;
    logic            redirect_rdy;
    logic            redirect_vld;
    robIdx_t         redirect_robIdx;
    logic [XLEN-1:0] redirect_pc;
    logic            filter_vld;

    branch_redirect_arb #(
        .NUM_BRU  (NUM_BRU),
        .ROB_SIZE (ROB_SIZE_DEF)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_bru_vld         (bru_vld),
        .i_bru_robIdx      (bru_robIdx),
        .i_bru_misPred     (bru_misPred),
        .i_bru_npc         (bru_npc),
        .i_commit_vld      (commit_vld),
        .i_commit_robIdx   (commit_robIdx),
        .i_rob_flush       (rob_flush),
        .o_redirect_vld    (redirect_vld),
        .o_redirect_robIdx (redirect_robIdx),
        .o_redirect_pc     (redirect_pc),
        .i_redirect_rdy    (redirect_rdy),
        .o_filter_vld      (filter_vld)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Indices are ring positions 0..RING-1; a is older than b when b lies
    // 1..ROB_SIZE-1 steps ahead of a on the ring.
    function automatic bit m_older(input int a, input int b);
        int d;
        d = (b - a + RING) % RING;
        return (d != 0) && (d < ROB_SIZE_DEF);
    endfunction

    bit              m_pv;
    int              m_pidx;
    logic [XLEN-1:0] m_ppc;
    bit              m_fv;
    int              m_fidx;

    // One clock: predict the next state from the present inputs, clock the
    // DUT, then compare.
    task automatic tick();
        bit              found;
        int              widx;
        logic [XLEN-1:0] wpc;
        bit              n_pv;
        int              n_pidx;
        logic [XLEN-1:0] n_ppc;
        bit              n_fv;
        int              n_fidx;
        found = 0; widx = 0; wpc = '0;
        n_pv = m_pv; n_pidx = m_pidx; n_ppc = m_ppc; n_fv = m_fv; n_fidx = m_fidx;
        if (rst) begin
            n_pv = 0; n_pidx = 0; n_ppc = '0; n_fv = 0; n_fidx = 0;
        end else if (rob_flush) begin
            n_pv = 0; n_fv = 0;
        end else begin
            for (int i = 0; i < NUM_BRU; i++) begin
                int c;
                c = int'(bru_robIdx[i]);
                if (bru_vld[i] && bru_misPred[i] && !(m_fv && !m_older(c, m_fidx))) begin
                    if (!found || m_older(c, widx)) begin
                        found = 1; widx = c; wpc = bru_npc[i];
                    end
                end
            end
            if (m_fv && commit_vld && int'(commit_robIdx) == m_fidx) n_fv = 0;
            if (m_pv && redirect_rdy) begin
                n_fv = 1; n_fidx = m_pidx;
                n_pv = found && m_older(widx, m_pidx);
                if (n_pv) begin n_pidx = widx; n_ppc = wpc; end
            end else if (m_pv) begin
                if (found && m_older(widx, m_pidx)) begin n_pidx = widx; n_ppc = wpc; end
            end else if (found) begin
                n_pv = 1; n_pidx = widx; n_ppc = wpc;
            end
        end
        @(posedge clk);
        #1;
        m_pv = n_pv; m_pidx = n_pidx; m_ppc = n_ppc; m_fv = n_fv; m_fidx = n_fidx;
        chk("redirect_vld", redirect_vld, m_pv);
        chk("filter_vld", filter_vld, m_fv);
        if (m_pv) begin
            chk("redirect_robIdx", redirect_robIdx, m_pidx);
            chk("redirect_pc", redirect_pc, m_ppc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        for (int i = 0; i < NUM_BRU; i++) begin
            bru_vld[i] = 0; bru_misPred[i] = 0; bru_robIdx[i] = '0; bru_npc[i] = '0;
        end
        commit_vld = 0; commit_robIdx = '0; rob_flush = 0;
    endtask

    task automatic mis(input int p, input int full, input logic [XLEN-1:0] npc);
        bru_vld[p] = 1; bru_misPred[p] = 1;
        bru_robIdx[p] = robIdx_t'(full); bru_npc[p] = npc;
    endtask

    task automatic commit(input int full);
        commit_vld = 1; commit_robIdx = robIdx_t'(full);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int head;
        m_pv = 0; m_pidx = 0; m_ppc = '0; m_fv = 0; m_fidx = 0;
        rst = 1; redirect_rdy = 0;
        idle();
        tick(); tick();
        chk("reset_robIdx", redirect_robIdx, 0);
        chk("reset_pc", redirect_pc, 0);
        rst = 0;

        // Basic mispredict, one-cycle latency, accept sets the filter.
        redirect_rdy = 1;
        mis(0, 5, 32'h8000_0100);
        tick();
        chk("t1_robIdx", redirect_robIdx, 5);
        chk("t1_pc", redirect_pc, 32'h8000_0100);
        idle(); tick();
        chk("t1_filter", filter_vld, 1);
        commit(5); tick(); idle();

        // Wrap: {1,2} is younger than {0,62}.
        redirect_rdy = 0;
        mis(0, 62, 32'h0000_1000); mis(1, 64 + 2, 32'h0000_2000);
        tick();
        chk("t2_robIdx", redirect_robIdx, 62);
        idle(); redirect_rdy = 1; tick();
        commit(62); redirect_rdy = 0; tick(); idle();

        // Stalled payload only gets older.
        mis(0, 10, 32'h0000_0a00); tick(); idle();
        mis(1, 8, 32'h0000_0800); tick(); idle();
        chk("t3_replace", redirect_robIdx, 8);
        mis(0, 12, 32'h0000_0c00); tick(); idle();
        chk("t3_keep", redirect_robIdx, 8);
        redirect_rdy = 1; tick(); redirect_rdy = 0;
        mis(0, 9, 32'h0000_0900); tick(); idle();
        chk("t3_dropped", redirect_vld, 0);
        commit(8); tick(); idle();
        chk("t3_released", filter_vld, 0);
        mis(0, 9, 32'h0000_0900); tick(); idle();
        chk("t3_redirect", redirect_robIdx, 9);
        redirect_rdy = 1; tick(); commit(9); redirect_rdy = 0; tick(); idle();

        // Flush during a stall, with a same-cycle input that must be ignored.
        mis(0, 3, 32'h0000_0300); tick(); idle();
        rob_flush = 1; mis(1, 1, 32'h0000_0100); tick(); idle();
        chk("t4_flush_vld", redirect_vld, 0);
        tick();
        // Flush on the accept cycle wins: no filter.
        mis(0, 20, 32'h0000_2020); tick(); idle();
        redirect_rdy = 1; rob_flush = 1; tick(); idle();
        chk("t4_flush_accept", filter_vld, 0);

        // Correct predictions never redirect.
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < NUM_BRU; i++) begin
                bru_vld[i] = 1; bru_misPred[i] = 0;
                bru_robIdx[i] = robIdx_t'($urandom_range(0, RING - 1));
                bru_npc[i] = $urandom;
            end
            redirect_rdy = 1'($urandom_range(0, 1));
            tick();
        end
        idle();

        // Randomized traffic around a moving ROB head.
        head = 0;
        for (int n = 0; n < 600; n++) begin
            head = (head + $urandom_range(0, 3)) % RING;
            for (int i = 0; i < NUM_BRU; i++) begin
                bru_vld[i]     = 1'($urandom_range(0, 1));
                bru_misPred[i] = ($urandom_range(0, 2) == 0);
                bru_robIdx[i]  = robIdx_t'((head + $urandom_range(0, 40)) % RING);
                bru_npc[i]     = $urandom;
            end
            commit_vld    = ($urandom_range(0, 2) == 0);
            commit_robIdx = ($urandom_range(0, 1) == 1) ? robIdx_t'(m_fidx)
                                                        : robIdx_t'($urandom_range(0, RING - 1));
            rob_flush     = ($urandom_range(0, 39) == 0);
            redirect_rdy  = ($urandom_range(0, 2) == 0);
            tick();
        end
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
